// File: rtl/otter_isa_pkg.sv
// OTTER RV32I opcode, command-class and loader-state definitions.
// Shared by the instruction packer and the loader encoder.
package otter_isa_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_SYS    = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [31:0] MRET = 32'h30200073;
   localparam logic [31:0] NOP  = 32'h00000013;

   typedef enum logic [3:0] {
      C_R      = 4'd0,
      C_I_ALU  = 4'd1,
      C_LOAD   = 4'd2,
      C_JALR   = 4'd3,
      C_STORE  = 4'd4,
      C_BRANCH = 4'd5,
      C_SYS    = 4'd6,
      C_LUI    = 4'd7,
      C_AUIPC  = 4'd8,
      C_JAL    = 4'd9
   } cmd_class_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/otter_instr_pack.sv
// Combinational packer: command fields to an RV32I word plus range flag.
// Out-of-range immediates are still packed, just truncated to the field.
module otter_instr_pack
   import otter_isa_pkg::*;
(
   input  logic [3:0]  cls,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  f3,
   input  logic        b30,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic        range_err
);

   logic fit12;
   logic fit13;
   logic fit21;
   logic shamt_ok;

   assign fit12    = imm[31:11] == {21{imm[11]}};
   assign fit13    = imm[31:12] == {20{imm[12]}};
   assign fit21    = imm[31:20] == {12{imm[20]}};
   assign shamt_ok = imm[31:5] == 27'd0;

   always_comb begin
      word      = NOP;
      range_err = 1'b0;
      case (cmd_class_t'(cls))
         C_R: begin
            word = {1'b0, b30, 5'b0, rs2, rs1, f3, rd, OP_R};
         end
         C_I_ALU: begin
            unique case (1'b1)
               (f3 == 3'b001): begin
                  word      = {7'b0, imm[4:0], rs1, f3, rd, OP_IMM};
                  range_err = !shamt_ok;
               end
               (f3 == 3'b101): begin
                  word      = {1'b0, b30, 5'b0, imm[4:0], rs1, f3, rd, OP_IMM};
                  range_err = !shamt_ok;
               end
               default: begin
                  word      = {imm[11:0], rs1, f3, rd, OP_IMM};
                  range_err = !fit12;
               end
            endcase
         end
         C_LOAD: begin
            word      = {imm[11:0], rs1, f3, rd, OP_LOAD};
            range_err = !fit12;
         end
         C_JALR: begin
            word      = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            range_err = !fit12;
         end
         C_STORE: begin
            word      = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            range_err = !fit12;
         end
         C_BRANCH: begin
            word      = {imm[12], imm[10:5], rs2, rs1, f3,
                         imm[4:1], imm[11], OP_BRANCH};
            range_err = !fit13 || imm[0];
         end
         C_SYS: begin
            word      = (f3 == 3'b000) ? MRET
                                       : {imm[11:0], rs1, f3, rd, OP_SYS};
            range_err = !fit12;
         end
         C_LUI: begin
            word      = {imm[31:12], rd, OP_LUI};
            range_err = imm[11:0] != 12'd0;
         end
         C_AUIPC: begin
            word      = {imm[31:12], rd, OP_AUIPC};
            range_err = imm[11:0] != 12'd0;
         end
         C_JAL: begin
            word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            range_err = !fit21 || imm[0];
         end
         default: begin
            word      = NOP;
            range_err = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/otter_instr_encoder.sv
// Loader front end: packs commands into RV32I words and streams them
// into IMEM through a single registered output stage.
module otter_instr_encoder
   import otter_isa_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 10
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  word_count,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_class,
   input  logic [4:0]        cmd_rd,
   input  logic [4:0]        cmd_rs1,
   input  logic [4:0]        cmd_rs2,
   input  logic [2:0]        cmd_f3,
   input  logic              cmd_b30,
   input  logic [31:0]       cmd_imm,
   output logic              imem_we,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   state_t            state;
   logic [ADDR_W-1:0] waddr;
   logic [CNT_W-1:0]  remaining;
   logic [31:0]       word;
   logic              rerr;
   logic              hs;
   logic              wr_done;

   otter_instr_pack u_pack (
      .cls       (cmd_class),
      .rd        (cmd_rd),
      .rs1       (cmd_rs1),
      .rs2       (cmd_rs2),
      .f3        (cmd_f3),
      .b30       (cmd_b30),
      .imm       (cmd_imm),
      .word      (word),
      .range_err (rerr)
   );

   // A new word may enter whenever the output slot is empty or draining now.
   assign cmd_ready = (state == S_LOAD) && (remaining != '0)
                   && (!imem_we || imem_ready);
   assign hs        = cmd_valid && cmd_ready;
   assign wr_done   = imem_we && imem_ready;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= S_IDLE;
         waddr      <= '0;
         remaining  <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         if (hs) begin
            imem_we    <= 1'b1;
            imem_addr  <= waddr;
            imem_wdata <= word;
            waddr      <= waddr + ADDR_W'(4);
         end else if (wr_done) begin
            imem_we <= 1'b0;
         end
         case (state)
            S_IDLE: begin
               if (start) begin
                  err       <= 1'b0;
                  busy      <= 1'b1;
                  waddr     <= base_addr & ~ADDR_W'(3);
                  remaining <= word_count;
                  if (word_count == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_LOAD;
                  end
               end
            end
            S_LOAD: begin
               if (hs) begin
                  remaining <= remaining - CNT_W'(1);
                  if (rerr) err <= 1'b1;
                  if (remaining == CNT_W'(1)) state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!imem_we || imem_ready) begin
                  state <= S_DONE;
                  done  <= 1'b1;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_otter_instr_encoder.sv
// Randomized scoreboard bench for otter_instr_encoder.
// Expected words come from an arithmetic model of the RV32I formats.
module tb_otter_instr_encoder;

   localparam int AW = 16;
   localparam int CW = 10;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [CW-1:0] word_count = '0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [3:0]    cmd_class = '0;
   logic [4:0]    cmd_rd = '0;
   logic [4:0]    cmd_rs1 = '0;
   logic [4:0]    cmd_rs2 = '0;
   logic [2:0]    cmd_f3 = '0;
   logic          cmd_b30 = 1'b0;
   logic [31:0]   cmd_imm = '0;
   logic          imem_we;
   logic          imem_ready = 1'b1;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          busy;
   logic          done;
   logic          err;

   otter_instr_encoder #(.ADDR_W(AW), .CNT_W(CW)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_class  (cmd_class),
      .cmd_rd     (cmd_rd),
      .cmd_rs1    (cmd_rs1),
      .cmd_rs2    (cmd_rs2),
      .cmd_f3     (cmd_f3),
      .cmd_b30    (cmd_b30),
      .cmd_imm    (cmd_imm),
      .imem_we    (imem_we),
      .imem_ready (imem_ready),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic        b30;
      logic [31:0] imm;
   } cmd_t;

   typedef struct {
      logic [AW-1:0] a;
      logic [31:0]   d;
   } exp_t;

   cmd_t        cmds[$];
   logic [31:0] lit[$];
   exp_t        sb[$];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int nwr = 0;
   int last_wr_cyc = 0;
   int run = 0;
   int maxrun = 0;
   int rmode = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, expv);
      end
   endtask

   // imem back-pressure: 0 always ready, 1 random, 2 stalled
   always @(posedge CLK) begin
      #1;
      if (rmode == 0) imem_ready = 1'b1;
      else if (rmode == 1) imem_ready = ($urandom % 3) != 0;
      else imem_ready = 1'b0;
   end

   function automatic void model(input cmd_t c, output logic [31:0] w,
                                 output bit e);
      int s;
      logic [31:0] regs;
      s    = int'(c.imm);
      regs = (32'(c.rs1) << 15) | (32'(c.rd) << 7);
      e    = 0;
      case (c.cls)
         4'd0: w = (32'(c.b30) << 30) | (32'(c.rs2) << 20) | regs
                 | (32'(c.f3) << 12) | 32'h33;
         4'd1: begin
            if (c.f3 == 3'd1 || c.f3 == 3'd5) begin
               w = (32'(s & 31) << 20) | regs | (32'(c.f3) << 12) | 32'h13;
               if (c.f3 == 3'd5) w = w | (32'(c.b30) << 30);
               e = (s < 0) || (s > 31);
            end else begin
               w = (32'(s & 'hFFF) << 20) | regs | (32'(c.f3) << 12) | 32'h13;
               e = (s < -2048) || (s > 2047);
            end
         end
         4'd2, 4'd3: begin
            w = (32'(s & 'hFFF) << 20) | regs
              | ((c.cls == 4'd2) ? ((32'(c.f3) << 12) | 32'h03) : 32'h67);
            e = (s < -2048) || (s > 2047);
         end
         4'd4: begin
            w = (32'((s >>> 5) & 'h7F) << 25) | (32'(c.rs2) << 20)
              | (32'(c.rs1) << 15) | (32'(c.f3) << 12)
              | (32'(s & 31) << 7) | 32'h23;
            e = (s < -2048) || (s > 2047);
         end
         4'd5: begin
            w = (32'((s >>> 12) & 1) << 31) | (32'((s >>> 5) & 'h3F) << 25)
              | (32'(c.rs2) << 20) | (32'(c.rs1) << 15) | (32'(c.f3) << 12)
              | (32'((s >>> 1) & 'hF) << 8) | (32'((s >>> 11) & 1) << 7)
              | 32'h63;
            e = (s < -4096) || (s > 4095) || (s % 2 != 0);
         end
         4'd6: begin
            if (c.f3 == 3'd0) w = 32'h30200073;
            else w = (32'(s & 'hFFF) << 20) | regs | (32'(c.f3) << 12) | 32'h73;
            e = (s < -2048) || (s > 2047);
         end
         4'd7, 4'd8: begin
            w = (c.imm & 32'hFFFFF000) | (32'(c.rd) << 7)
              | ((c.cls == 4'd7) ? 32'h37 : 32'h17);
            e = (c.imm % 4096) != 0;
         end
         4'd9: begin
            w = (32'((s >>> 20) & 1) << 31) | (32'((s >>> 1) & 'h3FF) << 21)
              | (32'((s >>> 11) & 1) << 20) | (32'((s >>> 12) & 'hFF) << 12)
              | (32'(c.rd) << 7) | 32'h6F;
            e = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
         end
         default: begin
            w = 32'h00000013;
            e = 1;
         end
      endcase
   endfunction

   function automatic cmd_t rnd_cmd();
      cmd_t c;
      logic [31:0] r;
      r     = $urandom;
      c.cls = 4'($urandom_range(0, 11));
      c.rd  = r[4:0];
      c.rs1 = r[9:5];
      c.rs2 = r[14:10];
      c.f3  = r[17:15];
      c.b30 = r[18];
      case ($urandom_range(0, 4))
         0: c.imm = $urandom;
         1: c.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
         2: c.imm = 32'($urandom_range(0, 31));
         3: c.imm = 32'((int'($urandom_range(0, 2097151)) - 1048576) & ~1);
         default: c.imm = $urandom & 32'hFFFFF000;
      endcase
      return c;
   endfunction

   function automatic cmd_t mk(input int cls, input int rd, input int rs1,
                               input int rs2, input int f3, input int b30,
                               input int imm);
      cmd_t c;
      c.cls = 4'(cls);
      c.rd  = 5'(rd);
      c.rs1 = 5'(rs1);
      c.rs2 = 5'(rs2);
      c.f3  = 3'(f3);
      c.b30 = 1'(b30);
      c.imm = 32'(imm);
      return c;
   endfunction

   task automatic drive(input cmd_t c);
      cmd_class = c.cls;
      cmd_rd    = c.rd;
      cmd_rs1   = c.rs1;
      cmd_rs2   = c.rs2;
      cmd_f3    = c.f3;
      cmd_b30   = c.b30;
      cmd_imm   = c.imm;
   endtask

   // Monitor: pops the scoreboard on every completed write and checks
   // that a stalled write holds its address and data.
   logic          hold_v = 1'b0;
   logic [AW-1:0] hold_a;
   logic [31:0]   hold_d;

   always @(negedge CLK) begin
      exp_t e;
      if (RST) begin
         hold_v = 1'b0;
         run    = 0;
      end else begin
         if (hold_v) begin
            chk("hold_we", 32'(imem_we), 32'd1);
            chk("hold_addr", 32'(imem_addr), 32'(hold_a));
            chk("hold_data", imem_wdata, hold_d);
         end
         hold_v = imem_we && !imem_ready;
         hold_a = imem_addr;
         hold_d = imem_wdata;
         if (imem_we && imem_ready) begin
            nwr++;
            last_wr_cyc = cyc;
            if (sb.size() == 0) begin
               chk("unexpected_write", imem_wdata, 32'hxxxxxxxx);
            end else begin
               e = sb.pop_front();
               chk("wr_addr", 32'(imem_addr), 32'(e.a));
               chk("wr_data", imem_wdata, e.d);
            end
         end
         if (cmd_valid && cmd_ready) begin
            run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
      end
   end

   task automatic do_burst(input logic [AW-1:0] base, input int exp_err,
                           input bit gaps);
      logic [AW-1:0] a;
      logic [31:0]   w;
      bit            e;
      bit            me;
      int            st_cyc;
      int            wr0;
      int            t;
      exp_t          x;
      a  = base & 16'hFFFC;
      me = 0;
      foreach (cmds[i]) begin
         model(cmds[i], w, e);
         if (lit.size() > i) w = lit[i];
         x.a = a;
         x.d = w;
         sb.push_back(x);
         a  = a + 16'd4;
         me = me | e;
      end
      @(posedge CLK); #1;
      start      = 1'b1;
      base_addr  = base;
      word_count = CW'(cmds.size());
      @(negedge CLK);
      st_cyc = cyc;
      chk("busy_before_start", 32'(busy), 32'd0);
      wr0 = nwr;
      @(posedge CLK); #1;
      start = 1'b0;
      foreach (cmds[i]) begin
         if (gaps && ($urandom % 4) == 0) begin
            cmd_valid = 1'b0;
            @(posedge CLK); #1;
         end
         drive(cmds[i]);
         cmd_valid = 1'b1;
         t = 0;
         @(negedge CLK);
         while (!cmd_ready && t < 200) begin
            t++;
            @(negedge CLK);
         end
         if (t >= 200) chk("cmd_timeout", 32'(cmd_ready), 32'd1);
         @(posedge CLK); #1;
      end
      cmd_valid = 1'b0;
      t = 0;
      @(negedge CLK);
      while (!done && t < 500) begin
         t++;
         @(negedge CLK);
      end
      chk("done_seen", 32'(done), 32'd1);
      chk("done_cycle", 32'(cyc),
          32'((nwr > wr0) ? last_wr_cyc + 1 : st_cyc + 1));
      chk("err", 32'(err), 32'((exp_err < 0) ? int'(me) : exp_err));
      chk("writes", 32'(nwr - wr0), 32'(cmds.size()));
      chk("sb_empty", 32'(sb.size()), 32'd0);
      @(negedge CLK);
      chk("done_pulse", 32'(done), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
      cmds.delete();
      lit.delete();
   endtask

   initial begin
      int t;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("rst_imem_we", 32'(imem_we), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      chk("rst_imem_wdata", imem_wdata, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;

      // sub x3,x1,x2
      cmds.push_back(mk(0, 3, 1, 2, 0, 1, 0));
      lit.push_back(32'h402081B3);
      do_burst(16'h1000, 0, 0);

      // addi / lui / jal back to back
      cmds.push_back(mk(1, 1, 0, 0, 0, 0, 5));
      cmds.push_back(mk(7, 2, 0, 0, 0, 0, 32'h12345000));
      cmds.push_back(mk(9, 0, 0, 0, 0, 0, -8));
      lit.push_back(32'h00500093);
      lit.push_back(32'h12345137);
      lit.push_back(32'hFF9FF06F);
      maxrun = 0;
      do_burst(16'h0000, 0, 0);
      chk("ready_run", 32'(maxrun), 32'd3);

      // four stalled cycles in the middle of a burst
      for (int i = 0; i < 6; i++) cmds.push_back(rnd_cmd());
      fork
         do_burst(16'h0400, -1, 0);
         begin
            repeat (4) @(negedge CLK);
            rmode = 2;
            repeat (4) begin
               @(negedge CLK);
               chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            end
            rmode = 0;
         end
      join

      // beq x1,x2,+16 then misaligned +17
      cmds.push_back(mk(5, 0, 1, 2, 0, 0, 16));
      lit.push_back(32'h00208863);
      do_burst(16'h0100, 0, 0);
      cmds.push_back(mk(5, 0, 1, 2, 0, 0, 17));
      lit.push_back(32'h00208863);
      do_burst(16'h0100, 1, 0);
      repeat (4) @(negedge CLK);
      chk("err_sticky", 32'(err), 32'd1);

      // empty burst clears err, no write
      do_burst(16'h0200, 0, 0);

      // address wrap
      cmds.push_back(rnd_cmd());
      cmds.push_back(rnd_cmd());
      do_burst(16'hFFFE, -1, 1);

      // reset after one of four words
      @(posedge CLK); #1;
      start      = 1'b1;
      base_addr  = 16'h0300;
      word_count = CW'(4);
      @(posedge CLK); #1;
      start = 1'b0;
      drive(mk(12, 0, 0, 0, 0, 0, 0));
      cmd_valid = 1'b1;
      t = 0;
      @(negedge CLK);
      while (!cmd_ready && t < 50) begin
         t++;
         @(negedge CLK);
      end
      chk("rstmid_accept", 32'(cmd_ready), 32'd1);
      @(posedge CLK); #1;
      cmd_valid = 1'b0;
      RST = 1'b1;
      @(negedge CLK);
      chk("pre_rst_err", 32'(err), 32'd1);
      @(negedge CLK);
      chk("rstmid_busy", 32'(busy), 32'd0);
      chk("rstmid_we", 32'(imem_we), 32'd0);
      chk("rstmid_addr", 32'(imem_addr), 32'd0);
      chk("rstmid_wdata", imem_wdata, 32'd0);
      chk("rstmid_err", 32'(err), 32'd0);
      chk("rstmid_ready", 32'(cmd_ready), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      sb.delete();

      for (int b = 0; b < 25; b++) begin
         int n;
         n     = $urandom_range(1, 8);
         rmode = $urandom_range(0, 1);
         for (int i = 0; i < n; i++) cmds.push_back(rnd_cmd());
         do_burst(16'($urandom), -1, 1'($urandom_range(0, 1)));
      end
      rmode = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/otter_instr_encoder.md
Name: otter_instr_encoder

Overview:
- Inverse of the CU decoder: turns field-level instruction commands (class, registers, funct3, bit30, immediate) into 32-bit RV32I words and writes them sequentially into OTTER instruction memory.
- Used by the boot/debug loader and by self-test benches to place programs without a prebuilt .mem file.
- Sits between the loader command stream (valid/ready) and the IMEM write port (valid/ready), with one registered output stage.

Parameters:
- ADDR_W, 16, byte-address width of the IMEM write port.
- CNT_W, 10, width of the word-count field for one load burst.

Ports:
- CLK  in  1  system clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a burst; ignored unless state is IDLE.
- base_addr  in  ADDR_W  byte address of the first word; bits [1:0] are ignored (forced 0).
- word_count  in  CNT_W  number of commands in the burst.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_class  in  4  class code from otter_isa_pkg: R, I_ALU, LOAD, JALR, STORE, BRANCH, SYS, LUI, AUIPC, JAL.
- cmd_rd, cmd_rs1, cmd_rs2  in  5 each  register indices.
- cmd_f3  in  3  funct3.
- cmd_b30  in  1  instruction bit 30 (sub/sra/srai select).
- cmd_imm  in  32  signed immediate as a byte offset or value (not pre-shifted).
- imem_we  out  1  write valid.
- imem_ready  in  1  memory accepts the write this cycle.
- imem_addr  out  ADDR_W  byte address of the write.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high while state is not IDLE.
- done  out  1  one-cycle pulse when the burst completes.
- err  out  1  sticky range/class error; cleared on the next accepted start.

Behaviour:
- Reset: state=IDLE. All outputs are 0: cmd_ready, imem_we, imem_addr, imem_wdata, busy, done, err. Internal counters are 0.
- FSM states:
  - IDLE: on start, go to LOAD. Latch addr=base_addr&~3 and remaining=word_count, clear err.
  - LOAD: on each handshake, register the encoded word into the output stage.
  - DRAIN: entered when the last command is accepted; wait for the output stage to empty.
  - DONE: assert done for one cycle, then go to IDLE.
- A start with word_count=0 goes IDLE→DONE directly. done is asserted in the cycle after start.
- cmd_ready = (state==LOAD) && (remaining!=0) && (!imem_we || imem_ready). This gives back-to-back throughput of 1 word/cycle.
- Latency: command handshake in cycle N; imem_we/imem_wdata valid in cycle N+1.
- imem_we, imem_addr and imem_wdata stay stable while imem_we && !imem_ready.
- imem_addr advances by 4 on each completed write and wraps modulo 2^ADDR_W without error.
- Encoding (opcodes match the decoder):
  - R: {0,b30,5'b0,rs2,rs1,f3,rd,0110011}.
  - I_ALU, f3=001: {7'b0,imm[4:0],rs1,f3,rd,0010011}.
  - I_ALU, f3=101: {0,b30,5'b0,imm[4:0],rs1,f3,rd,0010011}.
  - I_ALU, other f3: {imm[11:0],rs1,f3,rd,0010011}.
  - LOAD: opcode 0000011. JALR: opcode 1100111 with f3 forced to 000.
  - STORE: {imm[11:5],rs2,rs1,f3,imm[4:0],0100011}.
  - BRANCH: {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}.
  - SYS, f3≠000: {imm[11:0] as csr,rs1,f3,rd,1110011}. SYS, f3=000: fixed mret 0x30200073.
  - LUI/AUIPC: {imm[31:12],rd,0110111/0010111}.
  - JAL: {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}.
- Range checks; failure sets err, but the word is still written, with truncated fields:
  - I/LOAD/JALR/STORE/SYS: imm must fit 12-bit signed.
  - Shifts: imm in 0..31.
  - BRANCH: 13-bit signed and imm[0]=0.
  - JAL: 21-bit signed and imm[0]=0.
  - LUI/AUIPC: imm[11:0]=0.
- An unknown cmd_class sets err and writes 0x00000013 (nop).
- Simultaneous events:
  - A start while busy is ignored.
  - A handshake and an imem write completing in the same cycle load the output register and advance addr together.
- RST mid-burst: everything returns to reset values next cycle. No partial write is held.

Decomposition:
- otter_isa_pkg holds:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE, OP_BRANCH, OP_SYS, OP_LUI, OP_AUIPC, OP_JAL);
  - the cmd_class_t enum;
  - the MRET and NOP constants;
  - the state_t enum.
- Sub-module otter_instr_pack: purely combinational; takes the command fields and returns {word, range_err}. The FSM and output stage live in otter_instr_encoder.

Test Plan:
- start base_addr=0x1000, word_count=1, then R with rd=3, rs1=1, rs2=2, f3=000, b30=1 -> imem_we, addr=0x1000, wdata=0x402081B3 (sub x3,x1,x2); done is asserted one cycle after the write completes; err=0.
- Burst of 3 with imem_ready=1: addi x1,x0,5; lui x2,0x12345000; jal x0,-8 -> wdata 0x00500093, 0x12345137, 0xFF9FF06F at 0x0,0x4,0x8; cmd_ready is high on 3 consecutive cycles.
- Back-pressure: imem_ready=0 for 4 cycles mid-burst -> imem_addr/imem_wdata held constant, cmd_ready=0, no word lost or duplicated.
- beq x1,x2,+16 -> 0x00208863. The same branch with imm=+17 -> err=1 sticky until the next start.
- word_count=0 -> done asserted the cycle after start, no imem_we. base_addr=0xFFFC with 2 words -> second write at 0x0000.
- Assert RST mid-burst after 1 of 4 words -> next cycle busy=0, imem_we=0, all outputs 0. A subsequent start works normally.
